// File: rtl/timer_pkg.sv
// Shared timer/PWM definitions: state encoding, default widths
// and the registered output bundle of the dead-band stage.
package timer_pkg;

    localparam int DT_BITS_DEF = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DT_TO_HI = 3'd1;
    localparam logic [2:0] ST_HI_ON    = 3'd2;
    localparam logic [2:0] ST_DT_TO_LO = 3'd3;
    localparam logic [2:0] ST_LO_ON    = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;

    typedef struct packed {
        logic hi;
        logic lo;
        logic dt;
        logic flt;
    } drv_t;

endpackage

// File: rtl/pwm_dt_counter.sv
// Loadable dead-time down-counter; load clamps dead_cnt-1 at zero
// so a zero setting still yields a one-cycle gap.
import timer_pkg::*;

module pwm_dt_counter #(
    parameter int DT_BITS = DT_BITS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clr,
    input  logic               dec,
    input  logic [DT_BITS-1:0] dead_cnt,
    output logic [DT_BITS-1:0] cnt,
    output logic               done
);

    assign done = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (dead_cnt == '0) ? '0 : dead_cnt - 1'b1;
        end else if (clr) begin
            cnt <= '0;
        end else if (dec && !done) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pwm_deadband.sv
// Complementary gate-drive generator with dead time, sticky
// fault shutdown and enable blanking; all outputs are flops.
import timer_pkg::*;

module pwm_deadband #(
    parameter int DT_BITS = DT_BITS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pwm_in,
    input  logic               enable,
    input  logic [DT_BITS-1:0] dead_cnt,
    input  logic               fault,
    input  logic               fault_clr,
    output logic               pwm_hi,
    output logic               pwm_lo,
    output logic               dt_active,
    output logic               fault_latched
);

    logic [2:0]         state;
    logic [2:0]         state_nx;
    drv_t               drv;
    drv_t               drv_nx;
    logic               ctr_load;
    logic               ctr_clr;
    logic               ctr_dec;
    logic [DT_BITS-1:0] dt_ctr;
    logic               dt_done;

    pwm_dt_counter #(
        .DT_BITS (DT_BITS)
    ) u_dt_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ctr_load),
        .clr      (ctr_clr),
        .dec      (ctr_dec),
        .dead_cnt (dead_cnt),
        .cnt      (dt_ctr),
        .done     (dt_done)
    );

    always_comb begin
        state_nx = state;
        drv_nx   = '0;
        drv_nx.flt = drv.flt;
        ctr_load = 1'b0;
        ctr_clr  = 1'b0;
        ctr_dec  = 1'b0;

        if (fault) begin
            state_nx   = ST_FAULT;
            drv_nx.flt = 1'b1;
            ctr_clr    = 1'b1;
        end else if (state == ST_FAULT) begin
            // only an explicit clear leaves FAULT; enable has no say
            ctr_clr = 1'b1;
            if (fault_clr) begin
                state_nx   = ST_IDLE;
                drv_nx.flt = 1'b0;
            end
        end else if (!enable) begin
            state_nx = ST_IDLE;
            ctr_clr  = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    ctr_load  = 1'b1;
                    drv_nx.dt = 1'b1;
                    state_nx  = pwm_in ? ST_DT_TO_HI : ST_DT_TO_LO;
                end
                ST_DT_TO_HI: begin
                    if (!pwm_in) begin
                        state_nx  = ST_DT_TO_LO;
                        ctr_load  = 1'b1;
                        drv_nx.dt = 1'b1;
                    end else if (dt_done) begin
                        state_nx  = ST_HI_ON;
                        drv_nx.hi = 1'b1;
                    end else begin
                        ctr_dec   = 1'b1;
                        drv_nx.dt = 1'b1;
                    end
                end
                ST_HI_ON: begin
                    if (!pwm_in) begin
                        state_nx  = ST_DT_TO_LO;
                        ctr_load  = 1'b1;
                        drv_nx.dt = 1'b1;
                    end else begin
                        drv_nx.hi = 1'b1;
                    end
                end
                ST_DT_TO_LO: begin
                    if (pwm_in) begin
                        state_nx  = ST_DT_TO_HI;
                        ctr_load  = 1'b1;
                        drv_nx.dt = 1'b1;
                    end else if (dt_done) begin
                        state_nx  = ST_LO_ON;
                        drv_nx.lo = 1'b1;
                    end else begin
                        ctr_dec   = 1'b1;
                        drv_nx.dt = 1'b1;
                    end
                end
                ST_LO_ON: begin
                    if (pwm_in) begin
                        state_nx  = ST_DT_TO_HI;
                        ctr_load  = 1'b1;
                        drv_nx.dt = 1'b1;
                    end else begin
                        drv_nx.lo = 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    ctr_clr  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            drv   <= '0;
        end else begin
            state <= state_nx;
            drv   <= drv_nx;
        end
    end

    assign pwm_hi        = drv.hi;
    assign pwm_lo        = drv.lo;
    assign dt_active     = drv.dt;
    assign fault_latched = drv.flt;

endmodule

// File: tb/tb_pwm_deadband.sv
// Bench for pwm_deadband: vector table, hand corner sequences and
// random traffic against a run-length reference model.
module tb_pwm_deadband;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwm_in = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] dead_cnt = 8'd0;
    logic       fault = 1'b0;
    logic       fault_clr = 1'b0;
    logic       pwm_hi;
    logic       pwm_lo;
    logic       dt_active;
    logic       fault_latched;

    int n_chk = 0;
    int n_fail = 0;

    pwm_deadband #(.DT_BITS(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pwm_in        (pwm_in),
        .enable        (enable),
        .dead_cnt      (dead_cnt),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .pwm_hi        (pwm_hi),
        .pwm_lo        (pwm_lo),
        .dt_active     (dt_active),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    // Model: length of the current run of identical pwm_in samples
    // while active; the new side is on once the run exceeds the gap.
    int m_run = 0;
    int m_dc = 0;
    bit m_last = 0;
    bit m_flt = 0;
    bit m_act = 0;

    task automatic model_reset();
        m_run = 0; m_dc = 0; m_last = 0; m_flt = 0; m_act = 0;
    endtask

    task automatic model_edge();
        if (fault) begin
            m_flt = 1; m_act = 0; m_run = 0;
        end else if (m_flt) begin
            if (fault_clr) m_flt = 0;
            m_act = 0; m_run = 0;
        end else if (!enable) begin
            m_act = 0; m_run = 0;
        end else begin
            m_act = 1;
            if (m_run == 0 || pwm_in != m_last) begin
                m_run = 1;
                m_dc = int'(dead_cnt);
            end else if (m_run < 1000000) begin
                m_run++;
            end
            m_last = pwm_in;
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        int gap;
        gap = (m_dc == 0) ? 1 : m_dc;
        chk("model_hi", pwm_hi, m_act && m_last && m_run > gap);
        chk("model_lo", pwm_lo, m_act && !m_last && m_run > gap);
        chk("model_dt", dt_active, m_act && m_run <= gap);
        chk("model_flt", fault_latched, m_flt);
        chk("no_overlap", pwm_hi & pwm_lo, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk_model();
    endtask

    task automatic chk_out(input string name, input logic h, input logic l,
                           input logic d, input logic f);
        chk({name, "_hi"}, pwm_hi, h);
        chk({name, "_lo"}, pwm_lo, l);
        chk({name, "_dt"}, dt_active, d);
        chk({name, "_flt"}, fault_latched, f);
    endtask

    typedef struct {
        logic       pwm;
        logic       en;
        logic [7:0] dc;
        logic       flt;
        logic       clr;
        logic       e_hi;
        logic       e_lo;
        logic       e_dt;
        logic       e_flt;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic p, input logic e, input logic [7:0] d,
                                input logic f, input logic c, input logic h,
                                input logic l, input logic t, input logic x);
        vec_t v;
        v.pwm = p; v.en = e; v.dc = d; v.flt = f; v.clr = c;
        v.e_hi = h; v.e_lo = l; v.e_dt = t; v.e_flt = x;
        return v;
    endfunction

    task automatic set_in(input logic p, input logic e, input logic [7:0] d,
                          input logic f, input logic c);
        pwm_in = p; enable = e; dead_cnt = d; fault = f; fault_clr = c;
    endtask

    initial begin
        int hi_n;
        int lo_n;
        int k;
        bit seen_hi;
        int run_left;

        vecs[0]  = mk(0, 0, 2, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 2, 0, 0, 0, 0, 1, 0);
        vecs[2]  = mk(1, 1, 2, 0, 0, 0, 0, 1, 0);
        vecs[3]  = mk(1, 1, 2, 0, 0, 1, 0, 0, 0);
        vecs[4]  = mk(1, 1, 7, 0, 0, 1, 0, 0, 0);
        vecs[5]  = mk(0, 1, 1, 0, 0, 0, 0, 1, 0);
        vecs[6]  = mk(0, 1, 1, 0, 0, 0, 1, 0, 0);
        vecs[7]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 1);
        vecs[8]  = mk(0, 1, 1, 1, 1, 0, 0, 0, 1);
        vecs[9]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 1);
        vecs[10] = mk(0, 1, 1, 0, 1, 0, 0, 0, 0);
        vecs[11] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[12] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0);
        vecs[13] = mk(1, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[14] = mk(1, 1, 0, 0, 0, 1, 0, 0, 0);
        vecs[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);

        model_reset();
        #12;
        chk_out("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            set_in(vecs[i].pwm, vecs[i].en, vecs[i].dc, vecs[i].flt, vecs[i].clr);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].e_hi, vecs[i].e_lo,
                    vecs[i].e_dt, vecs[i].e_flt);
        end

        // async reset in HI_ON, then startup gap of 4
        set_in(1, 1, 2, 0, 0);
        repeat (4) tick();
        chk("pre_rst_hi", pwm_hi, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        set_in(1, 1, 4, 0, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("start_gap%0d", i), 0, 0, 1, 0);
        end
        tick();
        chk_out("start_on", 1, 0, 0, 0);

        // steady 10/10 pwm with 3-cycle gap
        set_in(0, 1, 3, 0, 0);
        repeat (5) tick();
        chk("steady_lo_init", pwm_lo, 1'b1);
        for (int p = 0; p < 2; p++) begin
            hi_n = 0; lo_n = 0;
            pwm_in = 1'b1;
            for (int c = 0; c < 10; c++) begin
                tick();
                hi_n += int'(pwm_hi);
                lo_n += int'(pwm_lo);
            end
            pwm_in = 1'b0;
            for (int c = 0; c < 10; c++) begin
                tick();
                hi_n += int'(pwm_hi);
                lo_n += int'(pwm_lo);
            end
            n_chk++;
            if (hi_n != 7 || lo_n != 7) begin
                n_fail++;
                $display("FAIL steady_duty: got hi=%0d lo=%0d expected 7/7", hi_n, lo_n);
            end
        end

        // zero dead time: single-cycle gap on every toggle
        dead_cnt = 8'd0;
        for (int t = 0; t < 4; t++) begin
            pwm_in = ~pwm_in;
            tick();
            chk_out($sformatf("zdt_gap%0d", t), 0, 0, 1, 0);
            tick();
            chk_out($sformatf("zdt_on%0d", t), pwm_in, ~pwm_in, 0, 0);
            tick();
        end

        // glitch rejection from LO_ON with gap 5
        chk("glitch_pre_lo", pwm_lo, 1'b1);
        dead_cnt = 8'd5;
        seen_hi = 0;
        pwm_in = 1'b1;
        repeat (2) begin
            tick();
            seen_hi |= pwm_hi;
        end
        pwm_in = 1'b0;
        k = 0;
        for (int c = 1; c <= 20 && k == 0; c++) begin
            tick();
            seen_hi |= pwm_hi;
            if (pwm_lo) k = c;
        end
        chk("glitch_no_hi", seen_hi, 1'b0);
        n_chk++;
        if (k != 6) begin
            n_fail++;
            $display("FAIL glitch_lo_return: got edge %0d expected 6", k);
        end

        // enable drop inside DT_TO_LO with counter at 2
        set_in(1, 1, 3, 0, 0);
        repeat (8) tick();
        chk("en_pre_hi", pwm_hi, 1'b1);
        pwm_in = 1'b0;
        tick();
        chk_out("en_dt", 0, 0, 1, 0);
        enable = 1'b0;
        tick();
        chk_out("en_drop", 0, 0, 0, 0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("reen_gap%0d", i), 0, 0, 1, 0);
        end
        tick();
        chk_out("reen_on", 0, 1, 0, 0);

        // fault during HI_ON, clear only when fault is low
        pwm_in = 1'b1;
        repeat (5) tick();
        chk("flt_pre_hi", pwm_hi, 1'b1);
        fault = 1'b1;
        tick();
        chk_out("flt_hit", 0, 0, 0, 1);
        fault_clr = 1'b1;
        tick();
        chk_out("flt_clr_blocked", 0, 0, 0, 1);
        fault = 1'b0; fault_clr = 1'b0;
        tick();
        chk_out("flt_held", 0, 0, 0, 1);
        fault_clr = 1'b1;
        tick();
        chk_out("flt_cleared", 0, 0, 0, 0);
        fault_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("flt_resume_gap%0d", i), 0, 0, 1, 0);
        end
        tick();
        chk_out("flt_resume_on", 1, 0, 0, 0);

        // random traffic against the model
        run_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                pwm_in = ~pwm_in;
                run_left = $urandom_range(12, 1);
            end
            run_left--;
            if ($urandom_range(7, 0) == 0) dead_cnt = 8'($urandom_range(6, 0));
            enable = ($urandom_range(31, 0) != 0);
            fault = ($urandom_range(63, 0) == 0);
            fault_clr = ($urandom_range(7, 0) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
